// File: rtl/bus_pkg.sv
// Shared definitions for the bus endpoint: broadcast ID, ID width and the
// helper that extracts the destination ID from the top bits of a packet.
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

    // Packages cannot take parameters, so packets are passed in zero-extended
    // to MAX_W bits along with the index of their real MSB.
    localparam int MAX_W = 256;
    typedef logic [MAX_W-1:0] pkt_max_t;

    function automatic logic [ID_W-1:0] dst_of(input pkt_max_t pkt, input logic [7:0] msb);
        return pkt[msb -: ID_W];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with sticky overflow/underflow flags.
// A full FIFO accepts a write when a read frees a slot in the same cycle.
module sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8,
    localparam int CW = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(depth));
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
            if (wr && full && !rd) begin
                ovf <= 1'b1;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Storage is not reset; contents are invisible until pointers move past them.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/bus_endpoint_fifo.sv
// Per-device endpoint: TX FIFO toward the bus driver, RX FIFO from it,
// plus a sticky check for RX packets addressed to another device.
module bus_endpoint_fifo
    import bus_pkg::*;
#(
    parameter int              width = 16,
    parameter int              depth = 8,
    parameter logic [ID_W-1:0] ID    = 8'd0,
    parameter logic [ID_W-1:0] BCAST = BCAST_ID,
    localparam int CW = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dev_tx_push,
    input  logic [width-1:0] dev_tx_data,
    output logic             tx_full,
    output logic [CW-1:0]    tx_count,
    output logic             pndng,
    input  logic             pop,
    output logic [width-1:0] D_pop,
    input  logic             push,
    input  logic [width-1:0] D_push,
    input  logic             dev_rx_pop,
    output logic [width-1:0] dev_rx_data,
    output logic             rx_pndng,
    output logic [CW-1:0]    rx_count,
    output logic             tx_ovf,
    output logic             rx_ovf,
    output logic             tx_udf,
    output logic             rx_udf,
    output logic             misroute
);

    typedef logic [width-1:0] pkt_t;

    logic            tx_empty;
    logic            rx_empty;
    logic            rx_full;
    logic [ID_W-1:0] rx_dst;
    pkt_t            rx_pkt;

    sync_fifo #(.width(width), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (dev_tx_push),
        .wdata (dev_tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count),
        .ovf   (tx_ovf),
        .udf   (tx_udf)
    );

    sync_fifo #(.width(width), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push),
        .wdata (D_push),
        .rd    (dev_rx_pop),
        .rdata (dev_rx_data),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count),
        .ovf   (rx_ovf),
        .udf   (rx_udf)
    );

    assign pndng    = !tx_empty;
    assign rx_pndng = !rx_empty;
    assign rx_pkt   = D_push;
    assign rx_dst   = dst_of(MAX_W'(rx_pkt), 8'(width - 1));

    // Only packets the RX FIFO actually accepts are checked; they are stored regardless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            misroute <= 1'b0;
        end else if (push && (!rx_full || dev_rx_pop) && rx_dst != ID && rx_dst != BCAST) begin
            misroute <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Directed bench for bus_endpoint_fifo (ID=3, width=16, depth=8): a vector
// table for single-cycle behaviour plus sequences for fill, wrap and reset.
module tb_bus_endpoint_fifo;

    localparam int W = 16;
    localparam int D = 8;

    typedef struct packed {
        logic          rst_n;
        logic          tx_push;
        logic [W-1:0]  tx_data;
        logic          pop;
        logic          push;
        logic [W-1:0]  d_push;
        logic          rx_pop;
    } in_t;

    typedef struct packed {
        logic [3:0]    tx_count;
        logic          pndng;
        logic          tx_full;
        logic [W-1:0]  d_pop;
        logic [3:0]    rx_count;
        logic          rx_pndng;
        logic [W-1:0]  rx_data;
        logic          tx_ovf;
        logic          rx_ovf;
        logic          tx_udf;
        logic          rx_udf;
        logic          misroute;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         dev_tx_push;
    logic [W-1:0] dev_tx_data;
    logic         tx_full;
    logic [3:0]   tx_count;
    logic         pndng;
    logic         pop;
    logic [W-1:0] D_pop;
    logic         push;
    logic [W-1:0] D_push;
    logic         dev_rx_pop;
    logic [W-1:0] dev_rx_data;
    logic         rx_pndng;
    logic [3:0]   rx_count;
    logic         tx_ovf;
    logic         rx_ovf;
    logic         tx_udf;
    logic         rx_udf;
    logic         misroute;

    int checks = 0;
    int errors = 0;

    bus_endpoint_fifo #(.width(W), .depth(D), .ID(8'd3), .BCAST(8'hFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .dev_tx_push (dev_tx_push),
        .dev_tx_data (dev_tx_data),
        .tx_full     (tx_full),
        .tx_count    (tx_count),
        .pndng       (pndng),
        .pop         (pop),
        .D_pop       (D_pop),
        .push        (push),
        .D_push      (D_push),
        .dev_rx_pop  (dev_rx_pop),
        .dev_rx_data (dev_rx_data),
        .rx_pndng    (rx_pndng),
        .rx_count    (rx_count),
        .tx_ovf      (tx_ovf),
        .rx_ovf      (rx_ovf),
        .tx_udf      (tx_udf),
        .rx_udf      (rx_udf),
        .misroute    (misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mkIn(logic rst_n, logic txp, logic [W-1:0] txd, logic p,
                                 logic ps, logic [W-1:0] dp, logic rxp);
        in_t v;
        v.rst_n   = rst_n;
        v.tx_push = txp;
        v.tx_data = txd;
        v.pop     = p;
        v.push    = ps;
        v.d_push  = dp;
        v.rx_pop  = rxp;
        return v;
    endfunction

    function automatic out_t mkOut(logic [3:0] tc, logic pn, logic fl, logic [W-1:0] dp,
                                   logic [3:0] rc, logic rpn, logic [W-1:0] rd,
                                   logic tov, logic rov, logic tud, logic rud, logic mis);
        out_t v;
        v.tx_count = tc;
        v.pndng    = pn;
        v.tx_full  = fl;
        v.d_pop    = dp;
        v.rx_count = rc;
        v.rx_pndng = rpn;
        v.rx_data  = rd;
        v.tx_ovf   = tov;
        v.rx_ovf   = rov;
        v.tx_udf   = tud;
        v.rx_udf   = rud;
        v.misroute = mis;
        return v;
    endfunction

    task automatic applyStimulus(input in_t v);
        @(negedge clk);
        reset       = v.rst_n;
        dev_tx_push = v.tx_push;
        dev_tx_data = v.tx_data;
        pop         = v.pop;
        push        = v.push;
        D_push      = v.d_push;
        dev_rx_pop  = v.rx_pop;
    endtask

    task automatic step(input in_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = mkOut(tx_count, pndng, tx_full, D_pop, rx_count, rx_pndng, dev_rx_data,
                    tx_ovf, rx_ovf, tx_udf, rx_udf, misroute);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    vec_t vecs[17];
    in_t  idle;
    out_t z;

    initial begin
        idle = mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        z    = mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = '{"reset_beats_push", mkIn(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0377, 1'b0), z};
        vecs[1]  = '{"idle_after_reset", idle, z};
        vecs[2]  = '{"tx_write1", mkIn(1'b1, 1'b1, 16'h0301, 1'b0, 1'b0, 16'h0, 1'b0),
                     mkOut(4'd1, 1'b1, 1'b0, 16'h0301, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[3]  = '{"tx_write2", mkIn(1'b1, 1'b1, 16'h0302, 1'b0, 1'b0, 16'h0, 1'b0),
                     mkOut(4'd2, 1'b1, 1'b0, 16'h0301, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[4]  = '{"tx_pop1", mkIn(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0),
                     mkOut(4'd1, 1'b1, 1'b0, 16'h0302, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{"tx_pop2", mkIn(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0), z};
        vecs[6]  = '{"tx_underflow", mkIn(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[7]  = '{"rx_underflow", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        vecs[8]  = '{"rx_push_pop_empty", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h03AA, 1'b1),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd1, 1'b1, 16'h03AA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        vecs[9]  = '{"rx_bcast", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFFBB, 1'b0),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd2, 1'b1, 16'h03AA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
        vecs[10] = '{"rx_misroute", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h05CC, 1'b0),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd3, 1'b1, 16'h03AA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)};
        vecs[11] = '{"rx_read1", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd2, 1'b1, 16'hFFBB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)};
        vecs[12] = '{"rx_read2", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd1, 1'b1, 16'h05CC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)};
        vecs[13] = '{"rx_read3", mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1),
                     mkOut(4'd0, 1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)};
        vecs[14] = '{"reset_clears_flags", mkIn(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0), z};
        vecs[15] = '{"tx_push_pop_empty", mkIn(1'b1, 1'b1, 16'h0311, 1'b1, 1'b0, 16'h0, 1'b0),
                     mkOut(4'd1, 1'b1, 1'b0, 16'h0311, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[16] = '{"reset_again", mkIn(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0), z};

        reset       = 1'b0;
        dev_tx_push = 1'b0;
        dev_tx_data = '0;
        pop         = 1'b0;
        push        = 1'b0;
        D_push      = '0;
        dev_rx_pop  = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].in);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // TX fill, overflow and read+write while full
        for (int i = 0; i < D; i++) begin
            step(mkIn(1'b1, 1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0, 16'h0, 1'b0));
        end
        checkVal("fill_count", 32'(tx_count), 32'd8);
        checkVal("fill_full", 32'(tx_full), 32'd1);
        checkVal("fill_head", 32'(D_pop), 32'h0A00);
        step(mkIn(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, 1'b0));
        checkVal("ovf_count", 32'(tx_count), 32'd8);
        checkVal("ovf_flag", 32'(tx_ovf), 32'd1);
        checkVal("ovf_head", 32'(D_pop), 32'h0A00);
        step(mkIn(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0));
        checkVal("full_rw_count", 32'(tx_count), 32'd8);
        checkVal("full_rw_head", 32'(D_pop), 32'h0A01);
        checkVal("full_rw_full", 32'(tx_full), 32'd1);
        for (int i = 1; i < D; i++) begin
            checkVal("drain_order", 32'(D_pop), 32'(16'h0A00 + i));
            step(mkIn(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0));
        end
        checkVal("drain_last", 32'(D_pop), 32'hBEEF);
        step(mkIn(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0));
        checkVal("drain_count", 32'(tx_count), 32'd0);
        checkVal("drain_pndng", 32'(pndng), 32'd0);
        checkVal("ovf_sticky", 32'(tx_ovf), 32'd1);

        // RX fill and overflow
        for (int i = 0; i < D; i++) begin
            step(mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'(16'h0300 + i), 1'b0));
        end
        step(mkIn(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h03FF, 1'b0));
        checkVal("rx_ovf_flag", 32'(rx_ovf), 32'd1);
        checkVal("rx_ovf_count", 32'(rx_count), 32'd8);
        checkVal("rx_ovf_head", 32'(dev_rx_data), 32'h0300);
        checkVal("rx_no_misroute", 32'(misroute), 32'd0);

        // Mid-stream reset discards entries; then wrap the pointers
        step(mkIn(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            step(mkIn(1'b1, 1'b1, 16'(16'h0B00 + i), 1'b0, 1'b0, 16'h0, 1'b0));
        end
        checkVal("pre_reset_count", 32'(tx_count), 32'd5);
        step(mkIn(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0));
        checkOutput("mid_reset", z);
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] d;
            d = 16'(16'hC000 + k * 16'h0111);
            step(mkIn(1'b1, 1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0));
            checkVal("wrap_data", 32'(D_pop), 32'(d));
            checkVal("wrap_count1", 32'(tx_count), 32'd1);
            step(mkIn(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0));
            checkVal("wrap_count0", 32'(tx_count), 32'd0);
        end
        checkVal("wrap_no_udf", 32'(tx_udf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
